// File: rtl/pe_feeder_pkg.sv
// Shared constants, FSM state encoding and a small helper for the PE feeder.
package pe_feeder_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LOAD_NUM   = 4;
    localparam int INST_NUM   = 8;
    localparam int TX_NUM     = 2;
    localparam int ITER_NUM   = 3;
    localparam int ALPHA_NUM  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Buffers upstream samples and replays them to a non-stallable PE as fixed
// LOAD_N-word bursts separated by fixed gaps, ITER_N bursts per job.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_W     = DATA_WIDTH*2,
    parameter int FIFO_DEPTH = 32,
    parameter int LOAD_N     = LOAD_NUM,
    parameter int INST_N     = INST_NUM,
    parameter int TX_N       = TX_NUM,
    parameter int ITER_N     = ITER_NUM,
    parameter int ALPHA_N    = ALPHA_NUM
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              dout_pe_v,
    output logic [DATA_W-1:0] dout_pe,
    output logic              busy,
    output logic              done,
    output logic              err_underrun
);

    localparam int GAP_LEN   = INST_N + TX_N;
    localparam int DRAIN_LEN = INST_N + ALPHA_N + 1;
    localparam int PH_MAX    = maxOf(maxOf(LOAD_N, DRAIN_LEN), GAP_LEN);
    localparam int PH_W      = $clog2(PH_MAX + 1);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int ITER_W    = (ITER_N > 1) ? $clog2(ITER_N) : 1;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_rdData;
    logic [CNT_W-1:0]  w_count;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [ITER_W-1:0] r_iterCnt;
    logic              r_doutV;
    logic [DATA_W-1:0] r_dout;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
    assign s_ready      = rst & ~w_full;
    assign w_push       = s_valid & s_ready;
    assign w_pop        = (r_state == ST_BURST) & ~w_empty;

    assign dout_pe_v    = r_doutV;
    assign dout_pe      = r_dout;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_underrun = r_err;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_rdData),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Job sequencer with registered PE outputs; an empty FIFO in a burst emits a zero word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_iterCnt <= '0;
            r_doutV   <= 1'b0;
            r_dout    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_doutV <= 1'b0;
            r_dout  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if ((w_count >= CNT_W'(LOAD_N)) && !r_done) begin
                        r_state   <= ST_BURST;
                        r_phase   <= '0;
                        r_iterCnt <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_BURST: begin
                    r_doutV <= 1'b1;
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_dout <= w_rdData;
                    end
                    if (r_phase == PH_W'(LOAD_N - 1)) begin
                        r_phase <= '0;
                        if (r_iterCnt == ITER_W'(ITER_N - 1)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state   <= ST_GAP;
                            r_iterCnt <= r_iterCnt + ITER_W'(1);
                        end
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_phase == PH_W'(GAP_LEN - 1)) begin
                        r_phase <= '0;
                        r_state <= ST_BURST;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_phase == PH_W'(DRAIN_LEN - 1)) begin
                        r_phase <= '0;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: every accepted sample is queued and must
// reappear, in order, on the PE port; empty-FIFO burst slots must be zero.
module tb_pe_feeder;
    import pe_feeder_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          dout_pe_v;
    logic [DW-1:0] dout_pe;
    logic          busy;
    logic          done;
    logic          err_underrun;

    int total = 0;
    int bad   = 0;

    int            sampleIdx    = 0;
    int            popCount     = 0;
    int            doneCnt      = 0;
    int            doneIdx      = 0;
    int            lastWordIdx  = 0;
    int            readyRiseIdx = 0;
    int            burstStarts[$];
    logic [DW-1:0] expQ[$];
    bit            pendValid    = 1'b0;
    logic [DW-1:0] pendData     = '0;
    bit            prevV        = 1'b0;
    bit            prevReady    = 1'b1;
    bit            sawZero      = 1'b0;
    logic          prevErr      = 1'b0;
    logic          errAtFirstZero     = 1'b0;
    logic          errBeforeFirstZero = 1'b0;

    pe_feeder #(
        .DATA_W     (DW),
        .FIFO_DEPTH (16),
        .LOAD_N     (4),
        .INST_N     (8),
        .TX_N       (2),
        .ITER_N     (3),
        .ALPHA_N    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .dout_pe_v    (dout_pe_v),
        .dout_pe      (dout_pe),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // Samples at the falling edge; a handshake seen now is enqueued one sample
    // later, because the pop at the coming edge cannot yet see that word.
    task automatic monitorLoop();
        logic [DW-1:0] expWord;
        forever begin
            @(negedge clk);
            sampleIdx++;
            if (!rst) begin
                expQ.delete();
                burstStarts.delete();
                pendValid      = 1'b0;
                prevV          = 1'b0;
                prevReady      = 1'b1;
                sawZero        = 1'b0;
                prevErr        = 1'b0;
                errAtFirstZero = 1'b0;
            end else begin
                if (dout_pe_v) begin
                    if (!prevV) burstStarts.push_back(sampleIdx);
                    lastWordIdx = sampleIdx;
                    if (expQ.size() > 0) begin
                        expWord = expQ.pop_front();
                    end else begin
                        expWord = '0;
                        if (!sawZero) begin
                            sawZero            = 1'b1;
                            errAtFirstZero     = err_underrun;
                            errBeforeFirstZero = prevErr;
                        end
                    end
                    popCount++;
                    total++;
                    if (dout_pe !== expWord) begin
                        bad++;
                        $display("[TB] FAIL sb_word sample=%0d got=%h want=%h", sampleIdx, dout_pe, expWord);
                    end
                end else begin
                    total++;
                    if (dout_pe !== '0) begin
                        bad++;
                        $display("[TB] FAIL idle_zero sample=%0d got=%h want=0", sampleIdx, dout_pe);
                    end
                end
                if (done === 1'b1) begin
                    doneCnt++;
                    doneIdx = sampleIdx;
                end
                if (s_ready && !prevReady) readyRiseIdx = sampleIdx;
                prevV     = dout_pe_v;
                prevReady = s_ready;
                prevErr   = err_underrun;
                if (pendValid) expQ.push_back(pendData);
                pendValid = s_valid && s_ready;
                pendData  = s_data;
            end
        end
    endtask

    task automatic applyReset();
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offers words first..first+n-1 (value k*0x00010001), one per cycle when accepted.
    task automatic pushWords(input int first, input int n);
        bit          acc;
        logic [DW-1:0] k;
        for (int i = 0; i < n; i++) begin
            acc     = 1'b0;
            k       = DW'(first + i);
            s_valid = 1'b1;
            s_data  = k * 32'h00010001;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("[TB] FAIL push_timeout word=%0d got=not_accepted want=accepted", first + i);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int t;
        t = 0;
        while (doneCnt < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (doneCnt < target) begin
            bad++;
            $display("[TB] FAIL done_timeout got=%0d want=%0d", doneCnt, target);
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #1;
        total++;
        if ({s_ready, dout_pe_v, busy, done, err_underrun} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b want=00000", {s_ready, dout_pe_v, busy, done, err_underrun});
        end
        total++;
        if (dout_pe !== '0) begin
            bad++;
            $display("[TB] FAIL reset_dout got=%h want=0", dout_pe);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready got=%b want=1", s_ready);
        end
        total++;
        if (dut.u_fifo.o_count !== '0) begin
            bad++;
            $display("[TB] FAIL reset_count got=%0d want=0", dut.u_fifo.o_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_job();
        int d0, p0;
        d0 = doneCnt;
        p0 = popCount;
        pushWords(1, 12);
        waitDone(d0 + 1, 200);
        total++;
        if (burstStarts.size() != 3) begin
            bad++;
            $display("[TB] FAIL job_bursts got=%0d want=3", burstStarts.size());
        end
        if (burstStarts.size() >= 3) begin
            total++;
            if (burstStarts[1] - burstStarts[0] != 14) begin
                bad++;
                $display("[TB] FAIL job_period1 got=%0d want=14", burstStarts[1] - burstStarts[0]);
            end
            total++;
            if (burstStarts[2] - burstStarts[1] != 14) begin
                bad++;
                $display("[TB] FAIL job_period2 got=%0d want=14", burstStarts[2] - burstStarts[1]);
            end
        end
        total++;
        if (doneIdx - lastWordIdx != 13) begin
            bad++;
            $display("[TB] FAIL job_done_delay got=%0d want=13", doneIdx - lastWordIdx);
        end
        total++;
        if ({busy, err_underrun} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL job_end_flags got=%b want=00", {busy, err_underrun});
        end
        total++;
        if (popCount - p0 != 12 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL job_words got=%0d/%0d want=12/0", popCount - p0, expQ.size());
        end
    endtask

    task automatic test_underrun();
        int d0, p0;
        applyReset();
        d0 = doneCnt;
        p0 = popCount;
        pushWords(1, 6);
        waitDone(d0 + 1, 200);
        total++;
        if ({errBeforeFirstZero, errAtFirstZero} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL underrun_err_edge got=%b want=01", {errBeforeFirstZero, errAtFirstZero});
        end
        total++;
        if (doneIdx - lastWordIdx != 13) begin
            bad++;
            $display("[TB] FAIL underrun_done_delay got=%0d want=13", doneIdx - lastWordIdx);
        end
        total++;
        if (err_underrun !== 1'b1 || popCount - p0 != 12) begin
            bad++;
            $display("[TB] FAIL underrun_end got=%b/%0d want=1/12", err_underrun, popCount - p0);
        end
        pushWords(32, 12);
        total++;
        if (err_underrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL underrun_clear got=%b want=0", err_underrun);
        end
        waitDone(d0 + 2, 200);
        total++;
        if (err_underrun !== 1'b0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL underrun_next_job got=%b/%0d want=0/0", err_underrun, expQ.size());
        end
    endtask

    task automatic test_backpressure();
        int d0, p0;
        bit fullSeen, acc;
        logic [DW-1:0] k;
        applyReset();
        d0 = doneCnt;
        p0 = popCount;
        fullSeen = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            acc     = 1'b0;
            k       = DW'(i);
            s_valid = 1'b1;
            s_data  = k * 32'h00010001;
            for (int t = 0; t < 60 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready;
                if (!acc) begin
                    fullSeen = 1'b1;
                    total++;
                    if (dut.u_fifo.o_count !== 5'd16) begin
                        bad++;
                        $display("[TB] FAIL bp_full_count got=%0d want=16", dut.u_fifo.o_count);
                    end
                end
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("[TB] FAIL bp_push_timeout word=%0d got=not_accepted want=accepted", i);
            end
        end
        s_valid = 1'b0;
        total++;
        if (fullSeen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_ready_drop got=%b want=1", fullSeen);
        end
        waitDone(d0 + 2, 400);
        total++;
        if (burstStarts.size() < 3) begin
            bad++;
            $display("[TB] FAIL bp_bursts got=%0d want=6", burstStarts.size());
        end else if (readyRiseIdx != burstStarts[2]) begin
            bad++;
            $display("[TB] FAIL bp_ready_rise got=%0d want=%0d", readyRiseIdx, burstStarts[2]);
        end
        total++;
        if (popCount - p0 != 24 || expQ.size() != 1 || err_underrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_words got=%0d/%0d/%b want=24/1/0", popCount - p0, expQ.size(), err_underrun);
        end
    endtask

    task automatic test_threshold();
        int hsIdx;
        applyReset();
        pushWords(1, 3);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (busy !== 1'b0 || dut.r_state !== ST_IDLE || burstStarts.size() != 0) begin
            bad++;
            $display("[TB] FAIL thr_idle got=%b/%0d/%0d want=0/0/0", busy, dut.r_state, burstStarts.size());
        end
        total++;
        if (dut.u_fifo.o_count !== 5'd3) begin
            bad++;
            $display("[TB] FAIL thr_count got=%0d want=3", dut.u_fifo.o_count);
        end
        pushWords(4, 1);
        hsIdx = sampleIdx;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (burstStarts.size() == 0) begin
            bad++;
            $display("[TB] FAIL thr_latency got=none want=%0d", hsIdx + 3);
        end else if (burstStarts[0] != hsIdx + 3) begin
            bad++;
            $display("[TB] FAIL thr_latency got=%0d want=%0d", burstStarts[0], hsIdx + 3);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL thr_busy got=%b want=1", busy);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] k;
        applyReset();
        pushWords(1, 4);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            k       = DW'(16 + i);
            s_valid = 1'b1;
            s_data  = k * 32'h00010001;
            @(negedge clk);
            total++;
            if (dut.u_fifo.o_count !== 5'd4 || dut.r_state !== ST_BURST) begin
                bad++;
                $display("[TB] FAIL coll_count cycle=%0d got=%0d/%0d want=4/1", i, dut.u_fifo.o_count, dut.r_state);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.u_fifo.o_count !== 5'd4) begin
            bad++;
            $display("[TB] FAIL coll_count_end got=%0d want=4", dut.u_fifo.o_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midjob();
        int d0, t;
        applyReset();
        d0 = doneCnt;
        pushWords(1, 12);
        t = 0;
        while (!(burstStarts.size() >= 1 && !dout_pe_v && dut.r_state == ST_GAP) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (dut.r_state !== ST_GAP || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_pre got=%0d/%b want=2/1", dut.r_state, busy);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({s_ready, dout_pe_v, busy, done, err_underrun} !== 5'b0 || dout_pe !== '0) begin
            bad++;
            $display("[TB] FAIL mid_abort got=%b/%h want=00000/0", {s_ready, dout_pe_v, busy, done, err_underrun}, dout_pe);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1 || dut.u_fifo.o_count !== '0 || doneCnt != d0) begin
            bad++;
            $display("[TB] FAIL mid_release got=%b/%0d/%0d want=1/0/%0d", s_ready, dut.u_fifo.o_count, doneCnt, d0);
        end
        @(posedge clk);
        #1;
        pushWords(64, 12);
        waitDone(d0 + 1, 200);
        total++;
        if (err_underrun !== 1'b0 || expQ.size() != 0 || burstStarts.size() != 3) begin
            bad++;
            $display("[TB] FAIL mid_fresh_job got=%b/%0d/%0d want=0/0/3", err_underrun, expQ.size(), burstStarts.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        fork
            monitorLoop();
        join_none
        test_reset();
        test_full_job();
        test_underrun();
        test_backpressure();
        test_threshold();
        test_collision();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
